// File: rtl/softmax_pkg.sv
// softmax_pkg: shared types and constants for the softmax write-back path.
//   wr_state_t      - write-back FSM state encoding
//   SYM_BYTES_LOG2  - log2 of bytes per 128-bit bus symbol
//   MAX_BURST       - maximum symbols per write command
//   WCNT            - core words per bus symbol
package softmax_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_STREAM,
    S_WAIT,
    S_DONE
  } wr_state_t;

  localparam int SYM_BYTES_LOG2 = 4;
  localparam int MAX_BURST      = 32;
  localparam int WCNT           = 4;
endpackage

// File: rtl/softmax_word_packer.sv
// softmax_word_packer: packs NUM_LANES core words into one bus symbol.
//   clk, rst      - clock, synchronous active-low reset
//   acc           - a word is accepted this cycle
//   word          - the accepted word
//   last          - accepted word is the final word of the vector
//   full          - downstream buffer full, holds the pending symbol
//   beat_pending  - a completed symbol is waiting to be pushed
//   push          - symbol handed downstream this cycle
//   sym_data      - symbol register, lane 0 holds the first word
module softmax_word_packer
  import softmax_pkg::*;
#(
  parameter int NUM_LANES = softmax_pkg::WCNT,
  parameter int VEC_W     = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                acc,
  input  logic [VEC_W-1:0]                    word,
  input  logic                                last,
  input  logic                                full,
  output logic                                beat_pending,
  output logic                                push,
  output logic [NUM_LANES-1:0][VEC_W-1:0]     sym_data
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [LW-1:0] lane;

  // No word is accepted while a symbol is pending, so acc and push never coincide.
  assign push = beat_pending & ~full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lane         <= '0;
      beat_pending <= 1'b0;
      sym_data     <= '0;
    end else begin
      if (push) beat_pending <= 1'b0;
      if (acc) begin
        // Writing lane 0 clears the other lanes, so a short final symbol is zero padded.
        for (int k = 0; k < NUM_LANES; k++) begin
          if (lane == LW'(k))     sym_data[k] <= word;
          else if (lane == '0)    sym_data[k] <= '0;
        end
        if (lane == LW'(NUM_LANES-1) || last) begin
          lane         <= '0;
          beat_pending <= 1'b1;
        end else begin
          lane <= lane + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/softmax_wr_packer.sv
// softmax_wr_packer: write-back side of the softmax datapath. Packs 32-bit
// result words into bus symbols, issues burst write commands and streams the
// symbols into the Avalon write master's user buffer.
//   config_done/param_*        - job start pulse, destination address, length in words
//   core_wr_*                  - result word stream from the core (valid/ready)
//   wmst_*                     - write master command and user-buffer interface
//   wr_busy/wr_done            - job status
//   stall_cnt                  - only with SOFTMAX_WR_STALL_CNT_EN: cycles a symbol
//                                waited on a full buffer
module softmax_wr_packer
  import softmax_pkg::*;
#(
  parameter int XAW       = 32,
  parameter int XDW       = 128,
  parameter int DW        = 32,
  parameter int WCNT      = XDW / DW,
  parameter int MAX_BURST = softmax_pkg::MAX_BURST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            config_done,
  input  logic [XAW-1:0]  param_waddr,
  input  logic [XAW-1:0]  param_iolen,
  input  logic [DW-1:0]   core_wr_data,
  input  logic            core_wr_valid,
  output logic            core_wr_ready,
  output logic            wmst_fixed_location,
  output logic [XAW-1:0]  wmst_write_base,
  output logic [XAW-1:0]  wmst_write_length,
  output logic            wmst_go,
  input  logic            wmst_done,
  output logic            wmst_user_write_buffer,
  output logic [XDW-1:0]  wmst_user_buffer_data,
  input  logic            wmst_user_buffer_full,
  output logic            wr_busy,
`ifdef SOFTMAX_WR_STALL_CNT_EN
  output logic [31:0]     stall_cnt,
`endif
  output logic            wr_done
);
  localparam int LOG2W = $clog2(WCNT);

  wr_state_t      state;
  logic [XAW-1:0] addr, sym_left, burst, words_left, bw_left;
  logic [XAW-1:0] iolen_syms, sym_nxt, addr_nxt, wl_nxt, burst_nxt, bwl_nxt;
  logic           do_issue, do_finish;
  logic           beat_pending, push, word_acc, last_word;
  logic [WCNT-1:0][DW-1:0] sym;

  assign wmst_fixed_location    = 1'b0;
  assign wmst_user_buffer_data  = sym;
  assign wmst_user_write_buffer = push;
  assign core_wr_ready = (state == S_STREAM) && !beat_pending && (bw_left != '0);
  assign word_acc      = core_wr_valid && core_wr_ready;
  assign last_word     = (words_left == XAW'(1));

  // Next-command math is shared by the first command (from IDLE, using the
  // parameters) and follow-on commands (from WAIT, using the running state).
  always_comb begin
    iolen_syms = (param_iolen >> LOG2W) + XAW'(|param_iolen[LOG2W-1:0]);
    if (state == S_IDLE) begin
      sym_nxt  = iolen_syms;
      addr_nxt = param_waddr;
      wl_nxt   = param_iolen;
    end else begin
      sym_nxt  = sym_left - burst;
      addr_nxt = addr + (burst << SYM_BYTES_LOG2);
      wl_nxt   = words_left;
    end
    burst_nxt = (sym_nxt > XAW'(MAX_BURST)) ? XAW'(MAX_BURST) : sym_nxt;
    // The last burst may end on a partial symbol.
    bwl_nxt   = ((burst_nxt << LOG2W) > wl_nxt) ? wl_nxt : (burst_nxt << LOG2W);
    do_issue  = ((state == S_IDLE) && config_done && (param_iolen != '0)) ||
                ((state == S_WAIT) && wmst_done && (sym_nxt != '0));
    do_finish = ((state == S_IDLE) && config_done && (param_iolen == '0)) ||
                ((state == S_WAIT) && wmst_done && (sym_nxt == '0));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= S_IDLE;
      addr              <= '0;
      sym_left          <= '0;
      burst             <= '0;
      words_left        <= '0;
      bw_left           <= '0;
      wmst_go           <= 1'b0;
      wmst_write_base   <= '0;
      wmst_write_length <= '0;
      wr_busy           <= 1'b0;
      wr_done           <= 1'b0;
    end else begin
      wmst_go <= 1'b0;
      wr_done <= 1'b0;
      if (word_acc) begin
        words_left <= words_left - 1'b1;
        bw_left    <= bw_left - 1'b1;
      end
      if (do_issue) begin
        state             <= S_ISSUE;
        wmst_go           <= 1'b1;
        addr              <= addr_nxt;
        sym_left          <= sym_nxt;
        burst             <= burst_nxt;
        bw_left           <= bwl_nxt;
        words_left        <= wl_nxt;
        wmst_write_base   <= addr_nxt;
        wmst_write_length <= burst_nxt << SYM_BYTES_LOG2;
        wr_busy           <= 1'b1;
      end else if (do_finish) begin
        state    <= S_DONE;
        sym_left <= '0;
        wr_done  <= 1'b1;
        wr_busy  <= 1'b1;
      end else begin
        unique case (state)
          S_ISSUE:  state <= S_STREAM;
          // Leave on the push of the burst's final symbol.
          S_STREAM: if (push && bw_left == '0) state <= S_WAIT;
          S_DONE: begin
            state   <= S_IDLE;
            wr_busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  softmax_word_packer #(
    .NUM_LANES (WCNT),
    .VEC_W     (DW)
  ) u_pack (
    .clk          (clk),
    .rst          (rst),
    .acc          (word_acc),
    .word         (core_wr_data),
    .last         (last_word),
    .full         (wmst_user_buffer_full),
    .beat_pending (beat_pending),
    .push         (push),
    .sym_data     (sym)
  );

`ifdef SOFTMAX_WR_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)                                stall_cnt <= '0;
    else if (config_done)                    stall_cnt <= '0;
    else if (beat_pending && wmst_user_buffer_full && stall_cnt != '1)
                                             stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_softmax_wr_packer.sv
// tb_softmax_wr_packer: randomized self-checking bench for softmax_wr_packer.
// The bench plays the core (word source) and the write master (buffer-full,
// done pulses) and compares every cycle against a job model built from plain
// arithmetic: a command list and a list of expected packed symbols.
module tb_softmax_wr_packer;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         config_done = 1'b0;
  logic [31:0]  param_waddr = '0;
  logic [31:0]  param_iolen = '0;
  logic [31:0]  core_wr_data = '0;
  logic         core_wr_valid = 1'b0;
  logic         core_wr_ready;
  logic         wmst_fixed_location;
  logic [31:0]  wmst_write_base;
  logic [31:0]  wmst_write_length;
  logic         wmst_go;
  logic         wmst_done = 1'b0;
  logic         wmst_user_write_buffer;
  logic [127:0] wmst_user_buffer_data;
  logic         wmst_user_buffer_full = 1'b0;
  logic         wr_busy;
  logic         wr_done;
`ifdef SOFTMAX_WR_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  softmax_wr_packer dut (
    .clk                    (clk),
    .rst                    (rst),
    .config_done            (config_done),
    .param_waddr            (param_waddr),
    .param_iolen            (param_iolen),
    .core_wr_data           (core_wr_data),
    .core_wr_valid          (core_wr_valid),
    .core_wr_ready          (core_wr_ready),
    .wmst_fixed_location    (wmst_fixed_location),
    .wmst_write_base        (wmst_write_base),
    .wmst_write_length      (wmst_write_length),
    .wmst_go                (wmst_go),
    .wmst_done              (wmst_done),
    .wmst_user_write_buffer (wmst_user_write_buffer),
    .wmst_user_buffer_data  (wmst_user_buffer_data),
    .wmst_user_buffer_full  (wmst_user_buffer_full),
    .wr_busy                (wr_busy),
`ifdef SOFTMAX_WR_STALL_CNT_EN
    .stall_cnt              (stall_cnt),
`endif
    .wr_done                (wr_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // job model
  logic [31:0]  words[$];
  logic [31:0]  base_q[$];
  logic [31:0]  len_q[$];
  logic [127:0] sym_q[$];
  int iolen_m = 0, widx = 0, burst_out = 0, pushed = 0, done_cd = 0, hold_cnt = 0, cyc = 0;
  int fmode = 0, vmode = 0;
  bit pend_m = 0, hold_used = 0, in_job = 0, done_seen = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Commands: ceil(iolen/4) symbols split into bursts of at most 32, 16 bytes each.
  // Symbols: groups of four words, first word lowest, missing words zero.
  task automatic build_model(input logic [31:0] waddr, input int iolen, input bit seqw);
    int nsym, rem, b;
    logic [31:0] a;
    logic [127:0] s;
    words.delete(); base_q.delete(); len_q.delete(); sym_q.delete();
    for (int i = 0; i < iolen; i++) words.push_back(seqw ? 32'(i + 1) : $urandom);
    nsym = (iolen + 3) / 4;
    rem = nsym;
    a = waddr;
    while (rem > 0) begin
      b = (rem > 32) ? 32 : rem;
      base_q.push_back(a);
      len_q.push_back(32'(b * 16));
      a = a + 32'(b * 16);
      rem -= b;
    end
    for (int si = 0; si < nsym; si++) begin
      s = '0;
      for (int k = 0; k < 4; k++)
        if (si * 4 + k < iolen) s[32*k +: 32] = words[si*4+k];
      sym_q.push_back(s);
    end
    iolen_m = iolen;
    param_waddr = waddr;
    param_iolen = 32'(iolen);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},  core_wr_ready, 0);
    chk({tag, "_go"},     wmst_go, 0);
    chk({tag, "_push"},   wmst_user_write_buffer, 0);
    chk({tag, "_busy"},   wr_busy, 0);
    chk({tag, "_done"},   wr_done, 0);
    chk({tag, "_fixed"},  wmst_fixed_location, 0);
    chk({tag, "_base"},   wmst_write_base, 0);
    chk({tag, "_length"}, wmst_write_length, 0);
    chk({tag, "_data"},   wmst_user_buffer_data, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b0; config_done = 1'b0; core_wr_valid = 1'b0; wmst_done = 1'b0;
    wmst_user_buffer_full = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_all_zero(tag);
    in_job = 0; pend_m = 0; burst_out = 0; done_cd = 0; widx = 0; iolen_m = 0;
    base_q.delete(); len_q.delete(); sym_q.delete();
  endtask

  // One clock: drive inputs just after the edge, then check settled outputs.
  task automatic step(input bit cfg);
    @(posedge clk); #1;
    config_done = cfg;
    wmst_done = 1'b0;
    if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) begin wmst_done = 1'b1; burst_out = 0; end
    end
    case (fmode)
      0: wmst_user_buffer_full = 1'b0;
      1: wmst_user_buffer_full = ($urandom_range(0, 3) == 0);
      default: begin
        if (hold_cnt > 0) begin wmst_user_buffer_full = 1'b1; hold_cnt--; end
        else if (pend_m && !hold_used) begin
          wmst_user_buffer_full = 1'b1; hold_cnt = 9; hold_used = 1;
        end else wmst_user_buffer_full = 1'b0;
      end
    endcase
    core_wr_valid = (widx < iolen_m) && (vmode == 0 || $urandom_range(0, 1) == 1);
    core_wr_data  = (widx < iolen_m) ? words[widx] : $urandom;
    #1;
    if (!in_job) return;
    chk("fixed_location", wmst_fixed_location, 0);
    if (cyc == 1) begin
      chk("go_at_T1", wmst_go, iolen_m != 0);
      chk("done_at_T1", wr_done, iolen_m == 0);
    end
    if (cyc == 2 && iolen_m > 0) chk("ready_at_T2", core_wr_ready, 1);
    if (cyc >= 1) chk("busy", wr_busy, 1);
    if (wmst_go) begin
      chk("go_after_done", burst_out, 0);
      if (base_q.size() == 0) chk("unexpected_go", wmst_go, 0);
      else begin
        chk("cmd_base", wmst_write_base, base_q.pop_front());
        chk("cmd_length", wmst_write_length, len_q.pop_front());
      end
      burst_out = int'(wmst_write_length >> 4);
      pushed = 0;
    end
    if (pend_m) chk("ready_low_pending", core_wr_ready, 0);
    if (widx >= iolen_m) chk("ready_low_no_words", core_wr_ready, 0);
    chk("push", wmst_user_write_buffer, pend_m && !wmst_user_buffer_full);
    if (pend_m) chk("sym_data", wmst_user_buffer_data, (sym_q.size() > 0) ? sym_q[0] : 128'h0);
    if (wmst_user_write_buffer && pend_m) begin
      if (sym_q.size() > 0) void'(sym_q.pop_front());
      pend_m = 0;
      pushed++;
      if (pushed == burst_out) done_cd = $urandom_range(1, 4);
    end
    if (core_wr_valid && core_wr_ready && widx < iolen_m) begin
      if (widx % 4 == 3 || widx == iolen_m - 1) pend_m = 1;
      widx++;
    end
    if (wr_done) done_seen = 1;
  endtask

  task automatic run(input int fm, input int vm, input int abort_at);
    int budget;
    fmode = fm; vmode = vm;
    hold_used = 0; hold_cnt = 0; widx = 0; pend_m = 0; burst_out = 0; pushed = 0;
    done_cd = 0; done_seen = 0;
    in_job = 1;
    budget = iolen_m * 12 + 300;
    for (int c = 0; c < budget; c++) begin
      cyc = c;
      step(c == 0);
      if (done_seen) break;
      if (abort_at > 0 && c == abort_at) break;
    end
    if (abort_at > 0) begin
      do_reset("midrst");
      return;
    end
    chk("job_done_seen", done_seen, 1);
    chk("cmds_left", base_q.size(), 0);
    chk("syms_left", sym_q.size(), 0);
    chk("words_left", iolen_m - widx, 0);
    in_job = 0;
    step(0);
    chk("busy_after_done", wr_busy, 0);
    chk("done_single_pulse", wr_done, 0);
    if (!done_seen) do_reset("recover");
  endtask

  initial begin
    do_reset("reset");

    // iolen=8 at 0x1000, buffer never full
    build_model(32'h1000, 8, 1);
    chk("pin8_cmd", {base_q[0], len_q[0]}, {32'h1000, 32'd32});
    chk("pin8_sym0", sym_q[0], 128'h00000004_00000003_00000002_00000001);
    chk("pin8_sym1", sym_q[1], 128'h00000008_00000007_00000006_00000005);
    run(0, 0, 0);

    // iolen=5: partial final symbol
    build_model(32'h2000, 5, 1);
    chk("pin5_len", len_q[0], 32'd32);
    chk("pin5_sym1", sym_q[1], 128'h00000000_00000000_00000000_00000005);
    run(0, 1, 0);

    // iolen=200: two commands
    build_model(32'h1000, 200, 0);
    chk("pin200_cmd0", {base_q[0], len_q[0]}, {32'h1000, 32'd512});
    chk("pin200_cmd1", {base_q[1], len_q[1]}, {32'h1200, 32'd288});
    chk("pin200_nsym", sym_q.size(), 50);
    run(1, 1, 0);

    // buffer full for 10 cycles with a symbol pending
    build_model(32'h3000, 8, 0);
    run(2, 0, 0);

    // empty vector
    build_model(32'h4000, 0, 0);
    run(0, 0, 0);

    // reset mid-stream, then a clean job
    build_model(32'h5000, 40, 0);
    run(0, 0, 15);
    build_model(32'h5000, 13, 0);
    run(1, 1, 0);

    // random jobs
    for (int j = 0; j < 8; j++) begin
      build_model({12'h0, 16'($urandom_range(0, 16'hFFFF)), 4'h0},
                  $urandom_range(1, 300), 0);
      run($urandom_range(0, 2), $urandom_range(0, 1), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/softmax_wr_packer.md
# softmax_wr_packer

Write-back side of the softmax datapath. Accepts 32-bit result words from the softmax core and packs them into 128-bit bus symbols. Issues burst write commands to the Avalon write master and streams the packed symbols into the master's user buffer, so a result vector of `iolen` words lands at `waddr` in external memory. It mirrors the read-master/unpacker on the input side.

## Interface
Parameters:
- `XAW`, 32: external address and length width.
- `XDW`, 128: bus symbol width.
- `DW`, 32: core word width.
- `WCNT`, XDW/DW: words per symbol (4).
- `MAX_BURST`, 32: maximum symbols per write command.

Ports (`clk`/`rst`: single clock; reset is synchronous and active-low, i.e. `rst`==0 resets on a `clk` edge):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-low reset.
- `config_done` in 1: one-cycle pulse; latch parameters and start.
- `param_waddr` in XAW: destination byte address (16-byte aligned).
- `param_iolen` in XAW: vector length in words.
- `core_wr_data` in DW: result word.
- `core_wr_valid` in 1: word valid.
- `core_wr_ready` out 1: word accepted when valid&ready.
- `wmst_fixed_location` out 1: constant 0.
- `wmst_write_base` out XAW: burst byte address.
- `wmst_write_length` out XAW: burst byte length.
- `wmst_go` out 1: one-cycle command pulse.
- `wmst_done` in 1: pulse, burst fully written.
- `wmst_user_write_buffer` out 1: push symbol.
- `wmst_user_buffer_data` out XDW: packed symbol.
- `wmst_user_buffer_full` in 1: master buffer full; no push allowed.
- `wr_busy` out 1: job in progress.
- `wr_done` out 1: one-cycle pulse, job complete.

## Operation
- FSM states:
  - IDLE: on `config_done`, latch waddr and iolen, compute `sym_left` = ceil(iolen/WCNT). Go to ISSUE, or DONE if iolen==0.
  - ISSUE: `burst` = min(sym_left, MAX_BURST). Set base = addr and length = burst<<4. Pulse `wmst_go`. Go to STREAM.
  - STREAM: accept words and push symbols until `burst` symbols are pushed. Go to WAIT.
  - WAIT: on `wmst_done`, addr += burst<<4 and sym_left -= burst. If sym_left==0 go to DONE, else ISSUE.
  - DONE: pulse `wr_done`, go to IDLE.
- Packing:
  - Word k of a symbol goes to bits [32k+31:32k]; the first word is in the lowest lane.
  - A symbol is complete at lane WCNT-1 or at the last word of the vector. Unused lanes of a final partial symbol are zero.
  - A completed symbol sets `beat_pending`. The push fires when `beat_pending` && !`wmst_user_buffer_full`, which clears `beat_pending`.
- `core_wr_ready` = STREAM && !`beat_pending` && words remaining in the current burst > 0.
- `config_done` outside IDLE is ignored.
- A `wmst_done` outside WAIT is ignored. The master never asserts it early.
- Length arithmetic is XAW bits, unsigned. The word counter wrapping past iolen is impossible because iolen is latched.
- Reset (`rst`==0) at any point: FSM to IDLE, all counters and `beat_pending` cleared, a partial symbol discarded.

## Timing
- Output reset values:
  - `core_wr_ready`, `wmst_go`, `wmst_user_write_buffer`, `wr_busy`, `wr_done`, `wmst_fixed_location`: 0.
  - `wmst_write_base`, `wmst_write_length`, `wmst_user_buffer_data`: 0.
- Command timing: `config_done` at edge T puts the FSM in ISSUE at T+1, with `wmst_go` high for that one cycle. Base and length are valid from T+1 and held until the next ISSUE.
- Word timing: the first word can be accepted at T+2. The push is registered and happens the cycle after the lane-3 word is accepted. Steady-state throughput is 4 words per 5 cycles.
- `wmst_user_buffer_data` is stable while `beat_pending` is set.
- `wr_busy` is high from T+1 through the DONE cycle.
- iolen==0: `wr_done` at T+1, with no `wmst_go`.

## Configuration
- Macro `SOFTMAX_WR_STALL_CNT_EN`.
- Defined: adds output `stall_cnt` [31:0]. It counts cycles with `beat_pending` && `wmst_user_buffer_full`, clears on `config_done`, saturates at 0xFFFFFFFF, and resets to 0.
- Undefined: neither the port nor the counter exists.

## Structure
- Shared package `softmax_pkg` holds:
  - the FSM state enum;
  - `SYM_BYTES_LOG2` = 4;
  - `MAX_BURST`;
  - `WCNT`.
- One sub-module, `softmax_word_packer`: lane counter, symbol register, zero-pad, `beat_pending`/push handshake. The top level keeps the FSM and address and length math.

## Test plan
- iolen=8, waddr=0x1000, buffer never full → one go with base 0x1000 and length 32. Two pushes: {w3,w2,w1,w0}, then {w7,w6,w5,w4}. After done, `wr_done` pulses once.
- iolen=5 → length 32; second symbol = {0,0,0,w4}.
- iolen=200, waddr=0x1000 → two commands: (0x1000, 512) then (0x1200, 288). The second go occurs only after the first done. 50 pushes total.
- `wmst_user_buffer_full` high for 10 cycles with a symbol pending → no push, data held stable, `core_wr_ready`=0. Push fires the cycle full drops.
- iolen=0 → `wr_done` at T+1, `wmst_go` never asserted.
- `rst`=0 mid-STREAM for one cycle → all outputs 0 next cycle. A new `config_done` then runs a clean job.
